// File: rtl/pipelined_processor_pkg.sv
// pipeline_pkg: shared opcodes, funct3 codes, writeback selects and stage bundles
// for pipelined_processor; imm_gen builds the sign-extended immediate of an RV32I word.
package pipeline_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } if_ex_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        mem_wr;
        logic [2:0]  funct3;
        wb_sel_e     wb_sel;
    } ex_wb_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] i);
        logic [31:0] r;
        case (i[6:0])
            OP_LUI, OP_AUIPC: r = {i[31:12], 12'b0};
            OP_JAL:    r = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            OP_BRANCH: r = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            OP_STORE:  r = {{21{i[31]}}, i[30:25], i[11:7]};
            default:   r = {{21{i[31]}}, i[30:20]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipelined_processor_branch_unit.sv
// branch_unit: combinational branch/jump resolution for the EX stage.
// In: rs1, rs2, funct3, opcode, pc, imm. Out: taken, target.
module branch_unit
    import pipeline_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  opcode,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic        taken,
    output logic [31:0] target
);
    logic cond;

    always_comb begin
        case (funct3)
            F3_BEQ:  cond = rs1 == rs2;
            F3_BNE:  cond = rs1 != rs2;
            F3_BLT:  cond = $signed(rs1) < $signed(rs2);
            F3_BGE:  cond = $signed(rs1) >= $signed(rs2);
            F3_BLTU: cond = rs1 < rs2;
            F3_BGEU: cond = rs1 >= rs2;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        taken  = 1'b0;
        target = pc + imm;
        unique case (1'b1)
            opcode == OP_BRANCH: taken = cond;
            opcode == OP_JAL:    taken = 1'b1;
            opcode == OP_JALR: begin
                taken  = 1'b1;
                target = (rs1 + imm) & ~32'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipelined_processor.sv
// pipelined_processor: 3-stage RV32I core (IF -> EX -> WB) with retirement counters.
// Ports: clock, reset (async, active high) in; retire_valid, retire_pc, instret_cnt,
// stall_cnt out. Macro FORWARDING_EN adds the WB->EX bypass; else RAW hazards stall.
module pipelined_processor
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter int          DMEM_DEPTH = 1024,
    parameter int          CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    output logic             retire_valid,
    output logic [31:0]      retire_pc,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    // Instruction ROM: contents are loaded from outside the core.
    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] rf   [32];
    logic [31:0] dmem [DMEM_DEPTH];

    logic [31:0] pc_q;
    if_ex_t      if_ex_q;
    ex_wb_t      ex_wb_q;
    ex_wb_t      ex_d;

    logic [31:0] inst, imm, rs1_v, rs2_v;
    logic [31:0] op_a, op_b, alu_y, wb_data, target;
    logic [6:0]  opcode;
    logic [2:0]  funct3, alu_fn;
    logic [4:0]  rs1_a, rs2_a, rd_a;
    logic        is_op, is_opimm, is_lui, is_auipc, is_jal;
    logic        is_jalr, is_load, is_store, is_branch;
    logic        reg_wr, mem_wr, alt, taken;
    logic        stall, redirect, hit1, hit2;
    wb_sel_e     wb_sel;

    // ---------------- EX: decode ----------------
    assign inst   = if_ex_q.inst;
    assign opcode = inst[6:0];
    assign rd_a   = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1_a  = inst[19:15];
    assign rs2_a  = inst[24:20];
    assign imm    = imm_gen(inst);

    assign is_op     = opcode == OP_OP;
    assign is_opimm  = opcode == OP_IMM;
    assign is_lui    = opcode == OP_LUI;
    assign is_auipc  = opcode == OP_AUIPC;
    assign is_jal    = opcode == OP_JAL;
    assign is_jalr   = opcode == OP_JALR;
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_branch = opcode == OP_BRANCH;

    always_comb begin
        reg_wr = 1'b0;
        mem_wr = 1'b0;
        wb_sel = WB_ALU;
        unique case (1'b1)
            is_load: begin
                reg_wr = 1'b1;
                wb_sel = WB_MEM;
            end
            is_store: mem_wr = 1'b1;
            is_jal, is_jalr: begin
                reg_wr = 1'b1;
                wb_sel = WB_PC4;
            end
            is_op, is_opimm, is_lui, is_auipc: reg_wr = 1'b1;
            default: ;
        endcase
    end

    // WB holds a live write to a register EX reads; x0 never matches.
    assign hit1 = ex_wb_q.valid && ex_wb_q.reg_wr &&
                  (ex_wb_q.rd != 5'd0) && (ex_wb_q.rd == rs1_a);
    assign hit2 = ex_wb_q.valid && ex_wb_q.reg_wr &&
                  (ex_wb_q.rd != 5'd0) && (ex_wb_q.rd == rs2_a);

`ifdef FORWARDING_EN
    assign rs1_v = hit1 ? wb_data : rf[rs1_a];
    assign rs2_v = hit2 ? wb_data : rf[rs2_a];
    assign stall = 1'b0;
`else
    logic use_rs1, use_rs2;
    assign use_rs1 = is_op || is_opimm || is_jalr ||
                     is_load || is_store || is_branch;
    assign use_rs2 = is_op || is_store || is_branch;
    assign rs1_v = rf[rs1_a];
    assign rs2_v = rf[rs2_a];
    assign stall = if_ex_q.valid &&
                   ((use_rs1 && hit1) || (use_rs2 && hit2));
`endif

    // ---------------- EX: ALU ----------------
    always_comb begin
        op_a = rs1_v;
        op_b = imm;
        unique case (1'b1)
            is_auipc: op_a = if_ex_q.pc;
            is_lui:   op_a = '0;
            default: ;
        endcase
        if (is_op || is_branch) op_b = rs2_v;
    end

    assign alu_fn = (is_op || is_opimm) ? funct3 : 3'd0;
    // inst[30] means sub for R-type and arithmetic shift for srai/sra.
    assign alt = inst[30] && (is_op || (is_opimm && funct3 == 3'd5));

    always_comb begin
        case (alu_fn)
            3'd0:    alu_y = alt ? op_a - op_b : op_a + op_b;
            3'd1:    alu_y = op_a << op_b[4:0];
            3'd2:    alu_y = {31'b0, $signed(op_a) < $signed(op_b)};
            3'd3:    alu_y = {31'b0, op_a < op_b};
            3'd4:    alu_y = op_a ^ op_b;
            3'd5:    alu_y = alt ? $unsigned($signed(op_a) >>> op_b[4:0])
                                 : op_a >> op_b[4:0];
            3'd6:    alu_y = op_a | op_b;
            default: alu_y = op_a & op_b;
        endcase
    end

    branch_unit u_branch (
        .rs1    (rs1_v),
        .rs2    (rs2_v),
        .funct3 (funct3),
        .opcode (opcode),
        .pc     (if_ex_q.pc),
        .imm    (imm),
        .taken  (taken),
        .target (target)
    );

    // A stalled instruction may not redirect until it can issue.
    assign redirect = if_ex_q.valid && taken && !stall;

    always_comb begin
        ex_d          = '0;
        ex_d.valid    = if_ex_q.valid;
        ex_d.pc       = if_ex_q.pc;
        ex_d.pc4      = if_ex_q.pc4;
        ex_d.alu      = alu_y;
        ex_d.rs2_data = rs2_v;
        ex_d.rd       = rd_a;
        ex_d.reg_wr   = if_ex_q.valid && reg_wr;
        ex_d.mem_wr   = if_ex_q.valid && mem_wr;
        ex_d.funct3   = funct3;
        ex_d.wb_sel   = wb_sel;
    end

    // ---------------- WB ----------------
    logic [DAW-1:0] d_idx;
    logic [1:0]     b_off;
    logic [31:0]    d_word, ld_sh, ld_val, st_data;
    logic [3:0]     st_be;

    assign d_idx  = ex_wb_q.alu[DAW+1:2];
    assign b_off  = ex_wb_q.alu[1:0];
    assign d_word = dmem[d_idx];
    assign ld_sh  = d_word >> {b_off, 3'b000};

    always_comb begin
        case (ex_wb_q.funct3)
            F3_LB:   ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
            F3_LH:   ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
            F3_LBU:  ld_val = {24'b0, ld_sh[7:0]};
            F3_LHU:  ld_val = {16'b0, ld_sh[15:0]};
            F3_LW:   ld_val = d_word;
            default: ld_val = d_word;
        endcase
    end

    always_comb begin
        case (ex_wb_q.funct3[1:0])
            2'd0: begin
                st_be   = 4'b0001 << b_off;
                st_data = {4{ex_wb_q.rs2_data[7:0]}};
            end
            2'd1: begin
                st_be   = 4'b0011 << b_off;
                st_data = {2{ex_wb_q.rs2_data[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = ex_wb_q.rs2_data;
            end
        endcase
    end

    always_comb begin
        case (ex_wb_q.wb_sel)
            WB_MEM:  wb_data = ld_val;
            WB_PC4:  wb_data = ex_wb_q.pc4;
            default: wb_data = ex_wb_q.alu;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (ex_wb_q.valid && ex_wb_q.reg_wr &&
                     ex_wb_q.rd != 5'd0) begin
            rf[ex_wb_q.rd] <= wb_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else if (ex_wb_q.valid && ex_wb_q.mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) dmem[d_idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            if_ex_q     <= '0;
            ex_wb_q     <= '0;
            instret_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (stall) begin
                ex_wb_q <= '0;
            end else begin
                ex_wb_q <= ex_d;
                if (redirect) begin
                    pc_q    <= target;
                    if_ex_q <= '0;
                end else begin
                    pc_q          <= pc_q + 32'd4;
                    if_ex_q.valid <= 1'b1;
                    if_ex_q.pc    <= pc_q;
                    if_ex_q.pc4   <= pc_q + 32'd4;
                    if_ex_q.inst  <= imem[pc_q[IAW+1:2]];
                end
            end
            if (ex_wb_q.valid) instret_cnt <= instret_cnt + CNT_W'(1);
            if (stall || redirect) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign retire_valid = ex_wb_q.valid;
    assign retire_pc    = ex_wb_q.valid ? ex_wb_q.pc : '0;

    logic unused_bits;
    assign unused_bits = ^{pc_q[1:0], pc_q[31:IAW+2], ex_wb_q.alu[31:DAW+2]};

endmodule

// File: tb/tb_pipelined_processor.sv
// tb_pipelined_processor: directed programs for pipelined_processor with
// immediate-assertion checks; expectations follow FORWARDING_EN when defined.
module tb_pipelined_processor;

    logic        clock;
    logic        reset;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] instret_cnt;
    logic [31:0] stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [31:0] prog [$];
    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    pipelined_processor dut (
        .clock        (clock),
        .reset        (reset),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .instret_cnt  (instret_cnt),
        .stall_cnt    (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] addi(input logic [31:0] rd, rs1, im);
        return {im[11:0], rs1[4:0], 3'b000, rd[4:0], 7'h13};
    endfunction
    function automatic logic [31:0] add(input logic [31:0] rd, rs1, rs2);
        return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] lui(input logic [31:0] rd, im);
        return {im[19:0], rd[4:0], 7'h37};
    endfunction
    function automatic logic [31:0] sw(input logic [31:0] rs2, rs1, im);
        return {im[11:5], rs2[4:0], rs1[4:0], 3'b010, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] lw(input logic [31:0] rd, rs1, im);
        return {im[11:0], rs1[4:0], 3'b010, rd[4:0], 7'h03};
    endfunction
    function automatic logic [31:0] beq(input logic [31:0] rs1, rs2, im);
        return {im[12], im[10:5], rs2[4:0], rs1[4:0], 3'b000,
                im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] jal(input logic [31:0] rd, im);
        return {im[20], im[10:1], im[11], im[19:12], rd[4:0], 7'h6F};
    endfunction
    function automatic logic [31:0] jalr(input logic [31:0] rd, rs1, im);
        return {im[11:0], rs1[4:0], 3'b000, rd[4:0], 7'h67};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++)
            dut.imem[i] = (i < prog.size()) ? prog[i] : NOP;
    endtask

    // Reset across one rising edge, then release on a falling edge (cycle 0).
    task automatic restart();
        @(negedge clock);
        reset = 1'b1;
        load_prog();
        @(negedge clock);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        logic saw4;
        reset = 1'b1;

        // T1: RAW dependency addi -> addi
        prog = '{addi(1, 0, 5), addi(2, 1, 3)};
        restart();
        check("reset_rv", {31'b0, retire_valid}, 32'd0);
        check("reset_instret", instret_cnt, 32'd0);
        tick_to(1);
        check("t1_c1_rv", {31'b0, retire_valid}, 32'd0);
        tick_to(2);
        check("t1_c2_rv", {31'b0, retire_valid}, 32'd1);
        check("t1_c2_pc", retire_pc, 32'h0);
        tick_to(3);
        check("t1_c3_rv", {31'b0, retire_valid}, FWD ? 32'd1 : 32'd0);
        check("t1_c3_pc", retire_pc, FWD ? 32'h4 : 32'h0);
        tick_to(4);
        check("t1_c4_pc", retire_pc, FWD ? 32'h8 : 32'h4);
        tick_to(10);
        check("t1_x1", dut.rf[1], 32'd5);
        check("t1_x2", dut.rf[2], 32'd8);
        check("t1_stall", stall_cnt, FWD ? 32'd0 : 32'd1);
        check("t1_instret", instret_cnt, FWD ? 32'd8 : 32'd7);

        // T2: store, load, load-use
        prog = '{lui(1, 1), addi(1, 1, 32'h234), sw(1, 0, 0),
                 lw(3, 0, 0), add(4, 3, 3)};
        restart();
        tick_to(20);
        check("t2_mem0", dut.dmem[0], 32'h1234);
        check("t2_x3", dut.rf[3], 32'h1234);
        check("t2_x4", dut.rf[4], 32'h2468);
        check("t2_stall", stall_cnt, FWD ? 32'd0 : 32'd3);

        // T3: taken beq skips one instruction
        prog = '{beq(0, 0, 8), addi(5, 0, 1), addi(6, 0, 2)};
        restart();
        tick_to(2);
        check("t3_c2_pc", retire_pc, 32'h0);
        tick_to(3);
        check("t3_c3_rv", {31'b0, retire_valid}, 32'd0);
        tick_to(4);
        check("t3_c4_pc", retire_pc, 32'h8);
        saw4 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (retire_valid && retire_pc == 32'h4) saw4 = 1'b1;
        end
        check("t3_skip_never_retires", {31'b0, saw4}, 32'd0);
        check("t3_x5", dut.rf[5], 32'd0);
        check("t3_x6", dut.rf[6], 32'd2);
        check("t3_stall", stall_cnt, 32'd1);

        // T4: jal at 0x10, jalr back to 0x14
        prog = '{NOP, NOP, NOP, NOP, jal(1, 12), addi(8, 0, 9),
                 jal(0, 0), jalr(0, 1, 0)};
        restart();
        tick_to(6);
        check("t4_c6_pc", retire_pc, 32'h10);
        tick_to(7);
        check("t4_c7_rv", {31'b0, retire_valid}, 32'd0);
        tick_to(8);
        check("t4_c8_pc", retire_pc, 32'h1C);
        check("t4_x1", dut.rf[1], 32'h14);
        tick_to(9);
        check("t4_c9_rv", {31'b0, retire_valid}, 32'd0);
        tick_to(10);
        check("t4_c10_pc", retire_pc, 32'h14);
        tick_to(14);
        check("t4_x8", dut.rf[8], 32'd9);
        check("t4_stall", stall_cnt, 32'd4);

        // T5: writes to x0 are dropped and never forwarded
        prog = '{addi(0, 0, 7), addi(7, 0, 0)};
        restart();
        tick_to(2);
        check("t5_c2_pc", retire_pc, 32'h0);
        tick_to(3);
        check("t5_c3_rv", {31'b0, retire_valid}, 32'd1);
        check("t5_c3_pc", retire_pc, 32'h4);
        tick_to(6);
        check("t5_x0", dut.rf[0], 32'd0);
        check("t5_x7", dut.rf[7], 32'd0);
        check("t5_stall", stall_cnt, 32'd0);

        // T6: asynchronous reset after 10 retirements
        prog = '{addi(1, 0, 5), addi(2, 1, 3)};
        restart();
        for (int k = 0; k < 40 && instret_cnt != 32'd10; k++) tick();
        check("t6_reach10", instret_cnt, 32'd10);
        reset = 1'b1;
        #1;
        check("t6_rst_rv", {31'b0, retire_valid}, 32'd0);
        check("t6_rst_pc", retire_pc, 32'd0);
        check("t6_rst_instret", instret_cnt, 32'd0);
        check("t6_rst_stall", stall_cnt, 32'd0);
        check("t6_rst_fetch_pc", dut.pc_q, 32'h0);
        check("t6_rst_x1", dut.rf[1], 32'd0);
        @(negedge clock);
        reset = 1'b0;
        cyc = 0;
        tick_to(1);
        check("t6_c1_rv", {31'b0, retire_valid}, 32'd0);
        tick_to(2);
        check("t6_c2_rv", {31'b0, retire_valid}, 32'd1);
        check("t6_c2_pc", retire_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
